// File: rtl/tanh_share_pkg.sv
// Shared definitions for the tanh PLA sharing arbiter: default sizing,
// the requester tag type and a tag-to-one-hot helper.
package tanh_share_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int TAG_W_DEF = 2;

   typedef logic [TAG_W_DEF-1:0] tag_t;

   // Requester index to one-hot requester vector.
   function automatic logic [N_REQ_DEF-1:0] onehot(input tag_t tag);
      logic [N_REQ_DEF-1:0] vec;
      vec      = '0;
      vec[tag] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/tanh_share_arbiter_if.sv
// Requester / PLA bus of the tanh sharing arbiter.
// slave  : the arbiter side.
// master : the gate-lane / PLA side (requesters and the external tanh unit).
interface tanh_share_arbiter_if
   import tanh_share_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W_IN  = 16,
   parameter int W_OUT = 16
);
   logic [N_REQ-1:0]      req_valid;
   logic [N_REQ*W_IN-1:0] req_data;
   logic [N_REQ-1:0]      req_ready;
   logic [W_IN-1:0]       pla_in;
   logic [W_OUT-1:0]      pla_out;
   logic [N_REQ-1:0]      rsp_valid;
   logic [W_OUT-1:0]      rsp_data;
   logic [N_REQ-1:0]      rsp_ready;
   logic                  busy;

   modport slave (
      input  req_valid, req_data, pla_out, rsp_ready,
      output req_ready, pla_in, rsp_valid, rsp_data, busy
   );

   modport master (
      output req_valid, req_data, pla_out, rsp_ready,
      input  req_ready, pla_in, rsp_valid, rsp_data, busy
   );
endinterface

// File: rtl/tanh_rr_arb.sv
// Round-robin arbiter: grants the first asserted request at or after the
// pointer, wrapping N_REQ-1 -> 0. The pointer moves past the winner only
// when the grant is actually taken (enable & |req).
module tanh_rr_arb
   import tanh_share_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             enable,
   output logic [N_REQ-1:0] grant,
   output logic [TAG_W-1:0] grant_idx
);

   logic [TAG_W-1:0] ptr;
   logic             found;
   int               idx;

   // Rotating priority search starting at the pointer.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = TAG_W'(idx);
         end
      end
   end

   // Pointer moves to winner+1 only when the grant is accepted.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (reset) begin
         ptr <= '0;
      end else if (enable && (|req)) begin
         ptr <= (grant_idx == TAG_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/tanh_share_arbiter.sv
// Shares one combinational tanh PLA between N_REQ requesters.
// S1 registers the granted operand (drives the PLA), S2 registers the PLA
// result and returns it one-hot to the originating requester.
// Optional build macro: TANH_SHARE_ARB_PERF_EN adds op_cnt / stall_cnt.
module tanh_share_arbiter
   import tanh_share_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W_IN  = 16,
   parameter int W_OUT = 16,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic                clock,
   input  logic                reset,
   tanh_share_arbiter_if.slave bus
`ifdef TANH_SHARE_ARB_PERF_EN
  ,output logic [31:0]         op_cnt,
   output logic [31:0]         stall_cnt
`endif
);

   logic             s1_vld, s2_vld;
   logic [TAG_W-1:0] s1_tag, s2_tag;
   logic [W_IN-1:0]  pla_in_q;
   logic [W_OUT-1:0] rsp_data_q;
   logic [N_REQ-1:0] rr_grant;
   logic [TAG_W-1:0] gnt_idx;
   logic             adv1, adv2, hs;

   // S2 moves when empty or its owner accepts; S1 moves when empty or S2 moves.
   assign adv2 = !s2_vld || bus.rsp_ready[s2_tag];
   assign adv1 = !s1_vld || adv2;

   assign bus.req_ready = adv1 ? rr_grant : '0;
   assign hs            = |(bus.req_valid & bus.req_ready);

   tanh_rr_arb #(
      .N_REQ (N_REQ),
      .TAG_W (TAG_W)
   ) u_arb (
      .clock     (clock),
      .reset     (reset),
      .req       (bus.req_valid),
      .enable    (adv1),
      .grant     (rr_grant),
      .grant_idx (gnt_idx)
   );

   // S1: capture the granted operand and its tag; drain to empty when nothing is granted.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_vld   <= 1'b0;
         s1_tag   <= '0;
         pla_in_q <= '0;
      end else if (adv1) begin
         s1_vld <= hs;
         if (hs) begin
            s1_tag   <= gnt_idx;
            pla_in_q <= bus.req_data[int'(gnt_idx)*W_IN +: W_IN];
         end
      end
   end

   // S2: capture the PLA result behind S1; hold everything under backpressure.
   always_ff @(posedge clock) begin
      if (reset) begin
         s2_vld     <= 1'b0;
         s2_tag     <= '0;
         rsp_data_q <= '0;
      end else if (adv2) begin
         s2_vld     <= s1_vld;
         s2_tag     <= s1_tag;
         rsp_data_q <= bus.pla_out;
      end
   end

   assign bus.pla_in    = pla_in_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_valid = s2_vld ? (N_REQ'(1) << s2_tag) : '0;
   assign bus.busy      = s1_vld | s2_vld;

`ifdef TANH_SHARE_ARB_PERF_EN
   // Free-running wrap-around counters of accepted operands and result stalls.
   always_ff @(posedge clock) begin
      if (reset) begin
         op_cnt    <= '0;
         stall_cnt <= '0;
      end else begin
         if (hs) op_cnt <= op_cnt + 32'd1;
         if (s2_vld && !bus.rsp_ready[s2_tag]) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
